// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage: instruction encodings,
// next-PC select encodings and the fetch FSM states.
package fetch_pkg;

    localparam int unsigned NB_INSTR = 32;

    localparam logic [NB_INSTR-1:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [NB_INSTR-1:0] HALT_INSTR = 32'hFFFF_FFFF;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_JR     = 2'b11;

    typedef enum logic [1:0] {
        LOAD   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_e;

endpackage : fetch_pkg

// File: rtl/fetch_unit_instr_mem.sv
// Instruction memory: one synchronous write port (program load) and one
// asynchronous read port (fetch). Contents are not reset.
module instr_mem #(
    parameter int unsigned NB_DATA   = 32,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                         i_clock,
    input  logic                         i_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0]           i_wr_data,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_rd_addr,
    output logic [NB_DATA-1:0]           o_rd_data
);

    logic [NB_DATA-1:0] mem_q [MEM_DEPTH];

    // Program-load write
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    // Asynchronous fetch read
    always_comb begin
        o_rd_data = mem_q[i_rd_addr];
    end

endmodule : instr_mem

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC mux, LOAD/RUN/HALTED FSM
// and the instruction memory. Optional fetch counter under FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned NB_DATA   = 32,
    parameter int unsigned NB_PC     = 32,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_start,
    input  logic                         i_stall,
    input  logic [1:0]                   i_pc_src,
    input  logic [NB_PC-1:0]             i_branch_addr,
    input  logic [NB_PC-1:0]             i_jump_addr,
    input  logic [NB_PC-1:0]             i_jr_addr,
    input  logic                         i_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0]           i_wr_data,
    output logic [NB_PC-1:0]             o_pc,
    output logic [NB_PC-1:0]             o_pc_plus4,
    output logic [NB_DATA-1:0]           o_instruction,
    output logic                         o_halt,
    output logic                         o_running
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]                  o_fetch_count
`endif
);

    localparam int unsigned NB_ADDR = $clog2(MEM_DEPTH);

    state_e             state_q;
    state_e             state_d;
    logic [NB_PC-1:0]   pc_q;
    logic [NB_PC-1:0]   pc_d;
    logic [NB_PC-1:0]   pc_target;
    logic [NB_DATA-1:0] mem_rdata;
    logic [NB_ADDR-1:0] rd_addr;
    logic               mem_wr_en;
    logic               step_ok;
    logic               halt_hit;
    logic               pc_adv;

    // Word index of the current PC; wraps modulo MEM_DEPTH
    assign rd_addr = pc_q[NB_ADDR+1:2];

    instr_mem #(
        .NB_DATA   (NB_DATA),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_instr_mem (
        .i_clock   (i_clock),
        .i_wr_en   (mem_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (mem_rdata)
    );

    // Step qualification: HALT only taken on sequential flow, a redirect wins
    always_comb begin
        step_ok  = (state_q == RUN) && i_enable && !i_stall;
        halt_hit = step_ok && (i_pc_src == PC_SRC_SEQ)
                   && (mem_rdata == NB_DATA'(HALT_INSTR));
        pc_adv   = step_ok && !halt_hit;
    end

    // FSM state register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (i_start)  state_d = RUN;
            RUN:     if (halt_hit) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = LOAD;
        endcase
    end

    // FSM outputs: status flags, load-port gating and IF/ID instruction
    always_comb begin
        o_running     = 1'b0;
        o_halt        = 1'b0;
        mem_wr_en     = 1'b0;
        o_instruction = NB_DATA'(NOP_INSTR);
        case (state_q)
            LOAD: begin
                mem_wr_en = i_wr_en;
            end
            RUN: begin
                o_running     = 1'b1;
                o_instruction = mem_rdata;
            end
            HALTED: begin
                o_halt = 1'b1;
            end
            default: begin
                o_running = 1'b0;
            end
        endcase
    end

    // Next-PC mux: redirect target or sequential, word aligned
    always_comb begin
        case (i_pc_src)
            PC_SRC_BRANCH: pc_target = i_branch_addr;
            PC_SRC_JUMP:   pc_target = i_jump_addr;
            PC_SRC_JR:     pc_target = i_jr_addr;
            default:       pc_target = pc_q + NB_PC'(4);
        endcase
        pc_d = pc_q;
        if (state_q == LOAD) begin
            pc_d = '0;
        end else if (pc_adv) begin
            pc_d = pc_target & ~NB_PC'(3);
        end
    end

    // PC register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_pc       = pc_q;
    assign o_pc_plus4 = pc_q + NB_PC'(4);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;

    // Saturating count of cycles in which the PC advanced
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fetch_cnt_q <= '0;
        end else if (pc_adv && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign o_fetch_count = fetch_cnt_q;
`endif

endmodule : fetch_unit
